// File: rtl/full_err_expect_seq_pkg.sv
// Shared types for the expected-value sequencer: FSM states, width defaults, memory-control bundle.
package full_err_expect_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FULL   = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic                  wr_en;
        logic                  rd_en;
    } expected_int_32_6_t;

endpackage

// File: rtl/full_err_expect_seq_if.sv
// Load/stream/memory bundle of the expected-value sequencer; slave = sequencer, master = its environment.
interface full_err_expect_seq_if #(
    parameter int DATA_W = full_err_expect_seq_pkg::DATA_W_DEF,
    parameter int ADDR_W = full_err_expect_seq_pkg::ADDR_W_DEF
);
    logic [ADDR_W:0]   len;
    logic              load_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              rd_start;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              loaded;

    modport slave (
        input  len, load_start, in_valid, in_data, rd_start, out_ready, mem_rd_data,
        output in_ready, out_valid, out_data, out_last, mem_addr, mem_wr_en, mem_rd_en,
               mem_wr_data, loaded
    );

    modport master (
        output len, load_start, in_valid, in_data, rd_start, out_ready, mem_rd_data,
        input  in_ready, out_valid, out_data, out_last, mem_addr, mem_wr_en, mem_rd_en,
               mem_wr_data, loaded
    );
endinterface

// File: rtl/full_err_expect_skid.sv
// Two-entry output buffer, fall-through when empty (zero added latency).
// Holds head stable under backpressure; in_rdy drops only when both entries are occupied.
module full_err_expect_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy,
    output logic [1:0]   occ
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    always_comb begin
        in_rdy  = (cnt_q != 2'd2);
        out_vld = (cnt_q != 2'd0) || in_vld;
        out_dat = (cnt_q != 2'd0) ? head_q : (in_vld ? in_dat : '0);
        occ     = cnt_q;
        push    = in_vld && in_rdy;
        pop     = out_vld && out_rdy;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        case (cnt_q)
            2'd0: if (push && !pop) begin
                head_d = in_dat;
                cnt_d  = 2'd1;
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_dat;
                end else if (push) begin
                    tail_d = in_dat;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: if (pop) begin
                head_d = tail_q;
                cnt_d  = 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/full_err_expect_seq.sv
// Loads up to 64 expected words into external memory, then replays them on rd_start.
// First beat 2 cycles after rd_start; reads stall so buffered plus in-flight words never exceed 2.
module full_err_expect_seq
    import full_err_expect_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    full_err_expect_seq_if.slave bus
);
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic             rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
    logic             in_ready_q, in_ready_d, loaded_q, loaded_d;

    expected_int_32_6_t mem_ctl;
    logic [DATA_W-1:0]  wr_dat;
    logic [1:0]         occ;
    logic [2:0]         pend_sum;
    logic               sk_in_rdy, sk_vld, issue, last_pop, load_req;
    logic [DATA_W:0]    sk_dat;
    logic [CNT_W-1:0]   len_clamped;

    // Last-entry flag travels with the data so out_last needs no separate count.
    full_err_expect_skid #(.W(DATA_W + 1)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_pend_q),
        .in_dat  ({rd_last_q, bus.mem_rd_data}),
        .in_rdy  (sk_in_rdy),
        .out_vld (sk_vld),
        .out_dat (sk_dat),
        .out_rdy (bus.out_ready),
        .occ     (occ)
    );

    always_comb begin
        len_clamped = (bus.len > DEPTH) ? DEPTH : bus.len;
        load_req    = bus.load_start && (bus.len != '0);
        pend_sum    = {1'b0, occ} + {2'b00, rd_pend_q};
        issue       = (state_q == ST_STREAM) && sk_in_rdy && (pend_sum < 3'd2) && (rcnt_q < len_q);
        last_pop    = (state_q == ST_STREAM) && sk_vld && bus.out_ready && sk_dat[DATA_W];

        state_d   = state_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        rd_pend_d = 1'b0;
        rd_last_d = 1'b0;
        mem_ctl   = '0;
        wr_dat    = '0;

        case (state_q)
            ST_IDLE: if (load_req) begin
                state_d = ST_LOAD;
                len_d   = len_clamped;
                wcnt_d  = '0;
            end
            ST_LOAD: if (in_ready_q && bus.in_valid) begin
                mem_ctl.wr_en = 1'b1;
                mem_ctl.addr  = wcnt_q[ADDR_W-1:0];
                wr_dat        = bus.in_data;
                wcnt_d        = wcnt_q + ONE;
                if (wcnt_q == len_q - ONE) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (bus.rd_start) begin
                    state_d = ST_STREAM;
                    rcnt_d  = '0;
                end else if (load_req) begin
                    state_d = ST_LOAD;
                    len_d   = len_clamped;
                    wcnt_d  = '0;
                end
            end
            default: begin
                if (issue) begin
                    mem_ctl.rd_en = 1'b1;
                    mem_ctl.addr  = rcnt_q[ADDR_W-1:0];
                    rcnt_d        = rcnt_q + ONE;
                    rd_pend_d     = 1'b1;
                    rd_last_d     = (rcnt_q == len_q - ONE);
                end
                if (last_pop) state_d = ST_FULL;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD);
        loaded_d   = (state_d == ST_FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            in_ready_q <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_last_q  <= rd_last_d;
            in_ready_q <= in_ready_d;
            loaded_q   <= loaded_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.loaded      = loaded_q;
    assign bus.mem_addr    = mem_ctl.addr;
    assign bus.mem_wr_en   = mem_ctl.wr_en;
    assign bus.mem_rd_en   = mem_ctl.rd_en;
    assign bus.mem_wr_data = wr_dat;
    assign bus.out_valid   = sk_vld;
    assign bus.out_data    = sk_dat[DATA_W-1:0];
    assign bus.out_last    = sk_dat[DATA_W];
endmodule

// File: tb/tb_full_err_expect_seq.sv
// Bench for full_err_expect_seq: external memory model, expected-word queues, random handshakes.
module tb_full_err_expect_seq;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    full_err_expect_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    full_err_expect_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] load_vals[$];
    logic [DW-1:0] ref_mem[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_e;
    bit   load_exp = 1'b0;
    bit   stream_exp = 1'b0;
    int   wr_idx = 0, beats = 0, first_cyc = 0, last_cyc = 0, start_cyc = 0;
    int   issued = 0, accepted = 0;
    bit   hold_pend = 1'b0;
    logic [DW-1:0] hold_dat;
    logic hold_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // External expected-value memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
        bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : DW'($urandom);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            chk("wr_rd_excl", bus.mem_wr_en & bus.mem_rd_en, 0);
            if (!bus.mem_wr_en && !bus.mem_rd_en) begin
                chk("idle_addr", bus.mem_addr, 0);
                chk("idle_wdata", bus.mem_wr_data, 0);
            end
            if (!load_exp) chk("stray_wr", bus.mem_wr_en, 0);
            else if (bus.mem_wr_en) begin
                chk("wr_in_range", wr_idx < load_vals.size(), 1);
                chk("wr_addr", bus.mem_addr, wr_idx);
                chk("wr_data", bus.mem_wr_data, load_vals[wr_idx]);
                wr_idx++;
            end
            if (!stream_exp) begin
                chk("stray_rd", bus.mem_rd_en, 0);
                chk("stray_vld", bus.out_valid, 0);
            end else if (bus.mem_rd_en) begin
                chk("rd_pending_lt2", (issued - accepted) < 2, 1);
                issued++;
            end
            if (hold_pend) begin
                chk("hold_vld", bus.out_valid, 1);
                chk("hold_dat", bus.out_data, hold_dat);
                chk("hold_last", bus.out_last, hold_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", bus.out_data, mon_e);
                    chk("out_last", bus.out_last, exp_q.size() == 0);
                    if (beats == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats++;
                    accepted++;
                    if (exp_q.size() == 0) stream_exp = 1'b0;
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_dat  = bus.out_data;
            hold_last = bus.out_last;
        end
    end

    task automatic chk_rst(input string pre);
        chk({pre, "_in_ready"}, bus.in_ready, 0);
        chk({pre, "_out_valid"}, bus.out_valid, 0);
        chk({pre, "_out_last"}, bus.out_last, 0);
        chk({pre, "_out_data"}, bus.out_data, 0);
        chk({pre, "_loaded"}, bus.loaded, 0);
        chk({pre, "_wr_en"}, bus.mem_wr_en, 0);
        chk({pre, "_rd_en"}, bus.mem_rd_en, 0);
        chk({pre, "_addr"}, bus.mem_addr, 0);
        chk({pre, "_wdata"}, bus.mem_wr_data, 0);
    endtask

    task automatic do_load(input int n, input int vp, input bit noise, input bit gen, output int cycles);
        int eff;
        int k;
        bit acc;
        eff = (n > DEPTH) ? DEPTH : n;
        if (gen) begin
            load_vals = {};
            for (int i = 0; i < eff; i++) load_vals.push_back(DW'($urandom));
        end
        wr_idx = 0;
        load_exp = 1'b1;
        bus.len = 7'(n);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("loading_loaded", bus.loaded, 0);
        chk("loading_rdy", bus.in_ready, 1);
        k = 0;
        cycles = 0;
        while (k < eff && cycles < 2000) begin
            bus.in_valid = ($urandom_range(0, 99) < vp);
            bus.in_data  = load_vals[k];
            if (noise) begin
                bus.load_start = ($urandom_range(0, 7) == 0);
                bus.rd_start   = ($urandom_range(0, 7) == 0);
                bus.len        = 7'($urandom_range(1, 64));
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            cycles++;
            if (acc) k++;
        end
        bus.in_valid = 1'b0;
        bus.load_start = 1'b0;
        bus.rd_start = 1'b0;
        load_exp = 1'b0;
        chk("load_accepts", k, eff);
        chk("load_writes", wr_idx, eff);
        chk("loaded_set", bus.loaded, 1);
        chk("in_ready_off", bus.in_ready, 0);
        ref_mem = load_vals;
    endtask

    task automatic do_stream(input int mode, input bit also_load, input bit noise);
        int g;
        exp_q = ref_mem;
        beats = 0;
        issued = 0;
        accepted = 0;
        stream_exp = 1'b1;
        bus.rd_start = 1'b1;
        if (also_load) begin
            bus.load_start = 1'b1;
            bus.len = 7'd5;
            bus.in_valid = 1'b1;
        end
        start_cyc = cyc;
        tick();
        bus.rd_start = 1'b0;
        bus.load_start = 1'b0;
        bus.in_valid = 1'b0;
        chk("stream_loaded_drop", bus.loaded, 0);
        chk("stream_in_ready", bus.in_ready, 0);
        g = 0;
        while (stream_exp && g < 3000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (g % 4 == 0) || (g % 4 == 3);
                default: bus.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (noise) begin
                bus.rd_start   = ($urandom_range(0, 5) == 0);
                bus.load_start = ($urandom_range(0, 5) == 0);
                bus.len        = 7'($urandom_range(1, 64));
            end
            tick();
            g++;
        end
        bus.rd_start = 1'b0;
        bus.load_start = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_done", exp_q.size(), 0);
        chk("stream_beats", beats, ref_mem.size());
        chk("back_full", bus.loaded, 1);
        if (mode == 0) begin
            chk("first_beat_lat", first_cyc - start_cyc, 2);
            chk("no_bubbles", last_cyc - first_cyc, beats - 1);
        end
    endtask

    initial begin
        int c;
        int g;
        rst_n = 1'b0;
        bus.len = '0;
        bus.load_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.rd_start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk_rst("rst");
        rst_n = 1'b1;
        tick();

        // Zero-length load is ignored even with data offered.
        bus.len = '0;
        bus.load_start = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.load_start = 1'b0;
        tick();
        chk("len0_in_ready", bus.in_ready, 0);
        chk("len0_loaded", bus.loaded, 0);
        bus.in_valid = 1'b0;

        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (3) tick();
        chk("idle_rd_loaded", bus.loaded, 0);

        load_vals = {32'h11, 32'h22, 32'h33, 32'h44};
        do_load(4, 100, 1'b0, 1'b0, c);
        chk("load4_cycles", c, 4);
        do_stream(0, 1'b0, 1'b0);
        do_stream(2, 1'b0, 1'b0);
        do_stream(2, 1'b1, 1'b0);

        do_load(100, 70, 1'b1, 1'b1, c);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        chk("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        do_stream(1, 1'b0, 1'b0);
        do_stream(0, 1'b0, 1'b1);

        for (int it = 0; it < 6; it++) begin
            do_load($urandom_range(1, 70), 60, 1'b1, 1'b1, c);
            do_stream($urandom_range(0, 2), 1'b0, 1'b1);
        end

        // Reset during the third beat of a four-entry replay.
        do_load(4, 100, 1'b0, 1'b1, c);
        exp_q = ref_mem;
        beats = 0;
        issued = 0;
        accepted = 0;
        stream_exp = 1'b1;
        bus.out_ready = 1'b1;
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        g = 0;
        while (beats < 2 && g < 50) begin
            tick();
            g++;
        end
        chk("rst_beats_before", beats, 2);
        chk("rst_beat3_vld", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        stream_exp = 1'b0;
        exp_q = {};
        #1;
        chk_rst("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        repeat (4) tick();
        chk("post_rst_loaded", bus.loaded, 0);
        chk("post_rst_vld", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/full_err_expect_seq.md
FULL_ERR_EXPECT_SEQ -- requirements
Module: full_err_expect_seq

Interface
REQ-001 Parameter DATA_W, default 32, width of an expected-value word.
REQ-002 Parameter ADDR_W, default 6, expected-memory address width; DEPTH = 2**ADDR_W = 64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low; one clock domain only.
REQ-005 len  input  ADDR_W+1  entry count for the next load, sampled on accepted load_start.
REQ-006 load_start  input  1  single-cycle request to begin loading len expected values.
REQ-007 in_valid / in_data  input  1 / DATA_W  expected-value stream into the block.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 rd_start  input  1  single-cycle request to stream the loaded entries out.
REQ-010 out_valid / out_data / out_last  output  1 / DATA_W / 1  expected-value stream to the error unit.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 mem_addr / mem_wr_en / mem_rd_en / mem_wr_data  output  ADDR_W / 1 / 1 / DATA_W  drives the expected-value memory.
REQ-013 mem_rd_data  input  DATA_W  memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 loaded  output  1  high while a complete set of len entries is held (state FULL).

Function
REQ-015 States: IDLE, LOAD, FULL, STREAM; reset enters IDLE.
REQ-016 IDLE: load_start with len != 0 -> LOAD, latch min(len, 64), write counter = 0; len == 0 ignored.
REQ-017 LOAD: in_ready = 1; each in_valid & in_ready cycle asserts mem_wr_en combinationally, mem_addr = write counter, mem_wr_data = in_data, counter +1.
REQ-018 LOAD: acceptance of entry len-1 -> FULL on the next edge; in_ready is 0 in every other state.
REQ-019 FULL: loaded = 1; rd_start -> STREAM with read counter = 0; load_start -> LOAD (overwrite); simultaneous rd_start and load_start: rd_start wins.
REQ-020 STREAM: a read of address rcnt issues (mem_rd_en = 1) only if output-buffer occupancy plus in-flight reads < 2 and rcnt < len; rcnt +1 per issue.
REQ-021 Output buffer: 2-entry FIFO capturing mem_rd_data one cycle after each mem_rd_en; out_valid = buffer non-empty; out_data = head.
REQ-022 out_last = 1 on the beat carrying entry len-1 only.
REQ-023 Acceptance of the out_last beat -> FULL; memory contents retained so rd_start replays identical data.
REQ-024 Latency: rd_start at cycle N -> first mem_rd_en at N+1 -> out_valid at N+2; with out_ready held 1, one beat per cycle, no bubbles.
REQ-025 Backpressure: out_data and out_last hold stable while out_valid & !out_ready; no entry is lost or duplicated.
REQ-026 mem_wr_en and mem_rd_en are never both 1; when idle mem_addr = 0 and mem_wr_data = 0.
REQ-027 rd_start in IDLE, LOAD or STREAM and load_start in LOAD or STREAM are ignored.
REQ-028 len = 64 (7'd64) is legal; counters wrap cleanly without touching address 0 twice.

Reset
REQ-029 reset low asynchronously forces IDLE, counters = 0, buffer empty, in-flight flag = 0.
REQ-030 Reset values: in_ready 0, out_valid 0, out_last 0, out_data 0, loaded 0, mem_wr_en 0, mem_rd_en 0, mem_addr 0, mem_wr_data 0.
REQ-031 reset asserted mid-LOAD or mid-STREAM abandons the operation; the returned mem_rd_data is discarded and loaded stays 0 until the next full load.

Structure
REQ-032 Shared types package holds the state enumeration, DATA_W/ADDR_W defaults and the expected_int_32_6 memory-control bundle (addr, wr_en, rd_en).
REQ-033 The 2-entry output buffer is one sub-module, full_err_expect_skid, with valid/ready on both sides.
REQ-034 The memory is instantiated outside this block; no storage of expected values inside it beyond the 2-entry buffer.

Verification
REQ-035 Load len=4 with 0x11,0x22,0x33,0x44, in_valid held 1 -> 4 writes to addresses 0..3 on consecutive cycles, loaded = 1 one cycle after the 4th.
REQ-036 rd_start, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on cycles N+2..N+5, out_last only with 0x44, then FULL.
REQ-037 Stream len=64 with out_ready toggling 1,0,0,1 -> all 64 words in order, none duplicated, mem_rd_en never issues with 2 words pending.
REQ-038 rd_start and load_start in the same FULL cycle -> STREAM entered, no write occurs.
REQ-039 reset low during beat 3 of a 4-entry stream -> all outputs at reset values immediately, loaded = 0, rd_start then ignored.
REQ-040 load_start with len=0 -> stays IDLE, in_ready 0; len=100 -> exactly 64 writes.
